// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator with a latency-matched
//             pixel pipeline. Pixel addresses are issued LAT enabled cycles
//             ahead of the colour data they fetch. Sync, blanking, line/frame
//             markers and colour leave the block aligned at the pins.
//  Revision : 1.0  - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,    // visible pixels per line
    parameter int H_FP     = 16,     // horizontal front porch
    parameter int H_SYNC   = 96,     // hsync pulse width
    parameter int H_BP     = 48,     // horizontal back porch
    parameter int V_ACTIVE = 480,    // visible lines per frame
    parameter int V_FP     = 10,     // vertical front porch
    parameter int V_SYNC   = 2,      // vsync pulse width
    parameter int V_BP     = 33,     // vertical back porch
    parameter bit HS_POL   = 1'b0,   // hsync active level
    parameter bit VS_POL   = 1'b0,   // vsync active level
    parameter int LAT      = 2,      // upstream read latency, 0..4
    parameter int CW       = 4,      // input bits per colour channel
    parameter int OW       = 8,      // output bits per colour channel
    parameter int AW       = 10      // pixel address width
) (
    input  logic            pclk,
    input  logic            reset,
    input  logic            en,
    input  logic [3*CW-1:0] vga_data,
    output logic            req_valid,
    output logic [AW-1:0]   h_addr,
    output logic [AW-1:0]   v_addr,
    output logic            hsync,
    output logic            vsync,
    output logic            valid,
    output logic [OW-1:0]   vga_r,
    output logic [OW-1:0]   vga_g,
    output logic [OW-1:0]   vga_b,
    output logic            line_start,
    output logic            frame_start
);

    // ------------------------------------------------------------------------
    // Raster geometry. Regions in order: sync, back porch, active, front porch.
    // ------------------------------------------------------------------------
    localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_BEG = H_SYNC + H_BP;
    localparam int H_ACT_END = H_ACT_BEG + H_ACTIVE;
    localparam int V_ACT_BEG = V_SYNC + V_BP;
    localparam int V_ACT_END = V_ACT_BEG + V_ACTIVE;

    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam logic [XW-1:0] X_LAST    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT_BEG = XW'(H_ACT_BEG);
    localparam logic [YW-1:0] Y_ACT_BEG = YW'(V_ACT_BEG);

    // Bit positions of the per-pixel control flags carried down the delay line.
    localparam int SW    = 5;
    localparam int S_HS  = 4;
    localparam int S_VS  = 3;
    localparam int S_VLD = 2;
    localparam int S_LS  = 1;
    localparam int S_FS  = 0;

    // ------------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------------
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    // Column advances every enabled cycle; row advances on column wrap and
    // wraps itself on the same cycle at the end of the frame.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Request stage: region decode and pixel address, purely combinational
    // ------------------------------------------------------------------------
    logic          h_in_sync;
    logic          v_in_sync;
    logic          h_act;
    logic          v_act;
    logic [XW-1:0] x_rel;
    logic [YW-1:0] y_rel;
    logic          line_first;
    logic          frame_first;

    assign h_in_sync = (32'(x) < H_SYNC);
    assign v_in_sync = (32'(y) < V_SYNC);
    assign h_act     = (32'(x) >= H_ACT_BEG) && (32'(x) < H_ACT_END);
    assign v_act     = (32'(y) >= V_ACT_BEG) && (32'(y) < V_ACT_END);

    // Offsets into the active window; only meaningful while active, so the
    // modular wrap outside the window is masked below.
    assign x_rel = x - X_ACT_BEG;
    assign y_rel = y - Y_ACT_BEG;

    assign req_valid = h_act & v_act;
    assign h_addr    = req_valid ? AW'(x_rel) : '0;
    assign v_addr    = req_valid ? AW'(y_rel) : '0;

    // First visible pixel of a line, and of the frame (visible row 0).
    assign line_first  = req_valid && (x == X_ACT_BEG);
    assign frame_first = line_first && (y == Y_ACT_BEG);

    // ------------------------------------------------------------------------
    // Output-stage alignment: control flags ride a LAT+1 deep delay line so
    // they leave together with the colour fetched for the same pixel.
    // ------------------------------------------------------------------------
    logic [SW-1:0] slot_in;
    logic [SW-1:0] slot_next;
    logic [SW-1:0] dly [0:LAT];

    assign slot_in = {h_in_sync, v_in_sync, req_valid, line_first, frame_first};

    // Shift the control flags one slot per enabled cycle; cleared on reset so
    // the pins show an idle, blanked raster until real slots arrive.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= LAT; k++) begin
                dly[k] <= '0;
            end
        end else if (en) begin
            dly[0] <= slot_in;
            for (int k = 1; k <= LAT; k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    // The slot about to reach the pins: its request was issued LAT enabled
    // cycles ago, so vga_data in this cycle belongs to it.
    generate
        if (LAT == 0) begin : g_tap_direct
            assign slot_next = slot_in;
        end else begin : g_tap_delayed
            assign slot_next = dly[LAT-1];
        end
    endgenerate

    assign hsync       = dly[LAT][S_HS] ? HS_POL : ~HS_POL;
    assign vsync       = dly[LAT][S_VS] ? VS_POL : ~VS_POL;
    assign valid       = dly[LAT][S_VLD];
    assign line_start  = dly[LAT][S_LS];
    assign frame_start = dly[LAT][S_FS];

    // ------------------------------------------------------------------------
    // Colour path: split channels and widen by MSB-first replication so that
    // full-scale input maps to full-scale output.
    // ------------------------------------------------------------------------
    logic [CW-1:0] in_r;
    logic [CW-1:0] in_g;
    logic [CW-1:0] in_b;
    logic [OW-1:0] exp_r;
    logic [OW-1:0] exp_g;
    logic [OW-1:0] exp_b;

    assign in_r = vga_data[3*CW-1 -: CW];
    assign in_g = vga_data[2*CW-1 -: CW];
    assign in_b = vga_data[CW-1:0];

    generate
        if (OW == CW) begin : g_exp_pass
            assign exp_r = in_r;
            assign exp_g = in_g;
            assign exp_b = in_b;
        end else begin : g_exp_rep
            assign exp_r = {in_r, in_r[CW-1 -: OW-CW]};
            assign exp_g = {in_g, in_g[CW-1 -: OW-CW]};
            assign exp_b = {in_b, in_b[CW-1 -: OW-CW]};
        end
    endgenerate

    // Capture colour only for visible slots; blanking always drives black.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (en) begin
            if (slot_next[S_VLD]) begin
                vga_r <= exp_r;
                vga_g <= exp_g;
                vga_b <= exp_b;
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. Three instances
//             (default 640x480/LAT=2, 800x600 active-high/LAT=0, and a tiny
//             raster with LAT=4 and 4->6 bit widening) share clock, reset and
//             a random pixel enable. A behavioural raster model plus a table
//             of hand-derived checkpoints provide the expected values.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic        rv;
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        vld;
        logic        ls;
        logic        fs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, lat, cw, ow;
    } tim_t;

    typedef struct {
        int   inst;
        int   t;
        obs_t exp;
    } vec_t;

    logic        pclk  = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic [11:0] data [3];

    logic       rv_a, hs_a, vs_a, vld_a, ls_a, fs_a;
    logic [9:0] ha_a, va_a;
    logic [7:0] r_a, g_a, b_a;
    logic       rv_b, hs_b, vs_b, vld_b, ls_b, fs_b;
    logic [9:0] ha_b, va_b;
    logic [7:0] r_b, g_b, b_b;
    logic       rv_c, hs_c, vs_c, vld_c, ls_c, fs_c;
    logic [3:0] ha_c, va_c;
    logic [5:0] r_c, g_c, b_c;

    always #5 pclk = ~pclk;

    vga_timing_gen u_a (
        .pclk(pclk), .reset(reset), .en(en), .vga_data(data[0]),
        .req_valid(rv_a), .h_addr(ha_a), .v_addr(va_a),
        .hsync(hs_a), .vsync(vs_a), .valid(vld_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .LAT(0), .CW(4), .OW(8), .AW(10)
    ) u_b (
        .pclk(pclk), .reset(reset), .en(en), .vga_data(data[1]),
        .req_valid(rv_b), .h_addr(ha_b), .v_addr(va_b),
        .hsync(hs_b), .vsync(vs_b), .valid(vld_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .LAT(4), .CW(4), .OW(6), .AW(4)
    ) u_c (
        .pclk(pclk), .reset(reset), .en(en), .vga_data(data[2]),
        .req_valid(rv_c), .h_addr(ha_c), .v_addr(va_c),
        .hsync(hs_c), .vsync(vs_c), .valid(vld_c),
        .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    tim_t tp [3];
    vec_t vecs [$];
    int   tcnt   = 0;     // enabled cycles since reset release
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   abort  = 1'b0;
    int   hist_h [3][64];
    int   hist_v [3][64];

    // Replicate a CW-bit value into OW bits, MSB first.
    function automatic int rep(int c, int cw, int ow);
        return (c << (ow - cw)) | (c >> (2 * cw - ow));
    endfunction

    // Behavioural raster: position from the enabled-cycle count, output stage
    // is the same computation for the request made LAT+1 cycles earlier.
    function automatic obs_t model(tim_t p, int t);
        obs_t o = '0;
        int ht, vt, x, y, q, hb0, vb0;
        ht  = p.hs + p.hb + p.ha + p.hf;
        vt  = p.vs + p.vb + p.va + p.vf;
        hb0 = p.hs + p.hb;
        vb0 = p.vs + p.vb;
        x = t % ht;
        y = (t / ht) % vt;
        if (x >= hb0 && x < hb0 + p.ha && y >= vb0 && y < vb0 + p.va) begin
            o.rv = 1'b1;
            o.h  = 16'(x - hb0);
            o.v  = 16'(y - vb0);
        end
        if (t < p.lat + 1) begin
            o.hs = (p.hpol == 0);
            o.vs = (p.vpol == 0);
        end else begin
            q = t - p.lat - 1;
            x = q % ht;
            y = (q / ht) % vt;
            o.hs = (x < p.hs) ? (p.hpol != 0) : (p.hpol == 0);
            o.vs = (y < p.vs) ? (p.vpol != 0) : (p.vpol == 0);
            if (x >= hb0 && x < hb0 + p.ha && y >= vb0 && y < vb0 + p.va) begin
                o.vld = 1'b1;
                o.ls  = (x == hb0);
                o.fs  = (x == hb0) && (y == vb0);
                o.r   = 8'(rep((x - hb0) & 15, p.cw, p.ow));
                o.g   = 8'(rep((y - vb0) & 15, p.cw, p.ow));
                o.b   = 8'(rep(5, p.cw, p.ow));
            end
        end
        return o;
    endfunction

    function automatic obs_t mk(bit rv, int h, int v, bit hs, bit vs,
                                bit vld, bit ls, bit fs);
        obs_t o = '0;
        o.rv = rv; o.h = 16'(h); o.v = 16'(v);
        o.hs = hs; o.vs = vs; o.vld = vld; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic obs_t sample(int i);
        obs_t o = '0;
        case (i)
            0: begin
                o.rv = rv_a; o.h = 16'(ha_a); o.v = 16'(va_a);
                o.hs = hs_a; o.vs = vs_a; o.vld = vld_a; o.ls = ls_a; o.fs = fs_a;
                o.r = r_a; o.g = g_a; o.b = b_a;
            end
            1: begin
                o.rv = rv_b; o.h = 16'(ha_b); o.v = 16'(va_b);
                o.hs = hs_b; o.vs = vs_b; o.vld = vld_b; o.ls = ls_b; o.fs = fs_b;
                o.r = r_b; o.g = g_b; o.b = b_b;
            end
            default: begin
                o.rv = rv_c; o.h = 16'(ha_c); o.v = 16'(va_c);
                o.hs = hs_c; o.vs = vs_c; o.vld = vld_c; o.ls = ls_c; o.fs = fs_c;
                o.r = 8'(r_c); o.g = 8'(g_c); o.b = 8'(b_c);
            end
        endcase
        return o;
    endfunction

    task automatic compare(input string name, input int i, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s inst=%0d t=%0d actual=%h required=%h", name, i, tcnt, act, exp);
            if (n_miss >= 200) abort = 1'b1;
        end
    endtask

    // One clock: check all instances at the sample point, drive this cycle's
    // enable and memory data, then advance to the next sample point.
    task automatic cycle(input bit en_v);
        obs_t act;
        obs_t msk;
        int   k;
        for (int i = 0; i < 3; i++) begin
            act = sample(i);
            compare("model", i, act, model(tp[i], tcnt));
            msk = act;
            msk.r = '0; msk.g = '0; msk.b = '0;
            foreach (vecs[j]) begin
                if (vecs[j].inst == i && vecs[j].t == tcnt)
                    compare("table", i, msk, vecs[j].exp);
            end
            hist_h[i][tcnt % 64] = int'(act.h);
            hist_v[i][tcnt % 64] = int'(act.v);
        end
        en = en_v;
        for (int i = 0; i < 3; i++) begin
            if (en_v && tcnt >= tp[i].lat) begin
                k = (tcnt - tp[i].lat) % 64;
                data[i] = 12'(((hist_h[i][k] & 15) << 8) | ((hist_v[i][k] & 15) << 4) | 5);
            end else begin
                data[i] = 12'($urandom);
            end
        end
        @(posedge pclk);
        if (en_v && !reset) tcnt++;
        #1;
    endtask

    initial begin
        int cyc;
        tp[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 4, 8};
        tp[1] = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 0, 4, 8};
        tp[2] = '{5, 2, 3, 2, 4, 1, 2, 1, 0, 1, 4, 4, 6};

        // Hand-derived checkpoints: {instance, enabled cycle, expected}.
        vecs.push_back('{0, 0,     mk(0, 0,   0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 2,     mk(0, 0,   0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 3,     mk(0, 0,   0, 0, 0, 0, 0, 0)});
        vecs.push_back('{0, 98,    mk(0, 0,   0, 0, 0, 0, 0, 0)});
        vecs.push_back('{0, 99,    mk(0, 0,   0, 1, 0, 0, 0, 0)});
        vecs.push_back('{0, 803,   mk(0, 0,   0, 0, 0, 0, 0, 0)});
        vecs.push_back('{0, 1602,  mk(0, 0,   0, 1, 0, 0, 0, 0)});
        vecs.push_back('{0, 1603,  mk(0, 0,   0, 0, 1, 0, 0, 0)});
        vecs.push_back('{0, 28144, mk(1, 0,   0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 28147, mk(1, 3,   0, 1, 1, 1, 1, 1)});
        vecs.push_back('{0, 28783, mk(1, 639, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{0, 28784, mk(0, 0,   0, 1, 1, 1, 0, 0)});
        vecs.push_back('{0, 28787, mk(0, 0,   0, 1, 1, 0, 0, 0)});
        vecs.push_back('{0, 28947, mk(1, 3,   1, 1, 1, 1, 1, 0)});
        vecs.push_back('{1, 0,     mk(0, 0,   0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1, 1,     mk(0, 0,   0, 1, 1, 0, 0, 0)});
        vecs.push_back('{1, 128,   mk(0, 0,   0, 1, 1, 0, 0, 0)});
        vecs.push_back('{1, 129,   mk(0, 0,   0, 0, 1, 0, 0, 0)});
        vecs.push_back('{1, 4224,  mk(0, 0,   0, 0, 1, 0, 0, 0)});
        vecs.push_back('{1, 4225,  mk(0, 0,   0, 1, 0, 0, 0, 0)});
        vecs.push_back('{1, 28728, mk(1, 0,   0, 0, 0, 0, 0, 0)});
        vecs.push_back('{1, 28729, mk(1, 1,   0, 0, 0, 1, 1, 1)});
        vecs.push_back('{2, 0,     mk(0, 0,   0, 1, 0, 0, 0, 0)});
        vecs.push_back('{2, 4,     mk(0, 0,   0, 1, 0, 0, 0, 0)});
        vecs.push_back('{2, 5,     mk(0, 0,   0, 0, 1, 0, 0, 0)});
        vecs.push_back('{2, 41,    mk(1, 0,   0, 0, 0, 0, 0, 0)});
        vecs.push_back('{2, 46,    mk(0, 0,   0, 1, 0, 1, 1, 1)});
        vecs.push_back('{2, 58,    mk(0, 0,   0, 1, 0, 1, 1, 0)});
        vecs.push_back('{2, 95,    mk(0, 0,   0, 1, 0, 0, 0, 0)});
        vecs.push_back('{2, 96,    mk(0, 0,   0, 1, 0, 0, 0, 0)});
        vecs.push_back('{2, 101,   mk(0, 0,   0, 0, 1, 0, 0, 0)});
        vecs.push_back('{2, 142,   mk(0, 0,   0, 1, 0, 1, 1, 1)});

        for (int i = 0; i < 3; i++) data[i] = '0;

        // Power-up reset, with enable high so nothing may advance under reset.
        repeat (3) @(posedge pclk);
        #1;
        repeat (3) cycle(1'b1);
        reset = 1'b0;

        // Main run: random enable, plus one 37-cycle stall mid-line.
        cyc = 0;
        while (tcnt < 30000 && cyc < 60000 && !abort) begin
            if (cyc == 5000) begin
                repeat (37) cycle(1'b0);
            end
            cycle($urandom_range(7, 0) != 0);
            cyc++;
        end

        // Mid-frame reset: takes effect without a clock edge.
        if (!abort) begin
            reset = 1'b1;
            tcnt  = 0;
            #2;
            for (int i = 0; i < 3; i++) compare("reset_async", i, sample(i), model(tp[i], 0));
            @(posedge pclk);
            #1;
            repeat (2) cycle(1'b1);
            reset = 1'b0;
            cyc = 0;
            while (tcnt < 1700 && cyc < 4000 && !abort) begin
                cycle($urandom_range(3, 0) != 0);
                cyc++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
